fetch_pc_sequencer: RTL and testbench

FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

---
 rtl/fetch_pc_sequencer_pkg.sv | 24 ++
 rtl/fetch_pc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared CPU-fetch definitions: sequencer state encoding and default bus sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pc_sequencer_pkg;

    // Default datapath width for PC, address and instruction buses.
    localparam int unsigned NR_OF_BITS_DEF   = 32;

    // Default sequential PC step (one 32-bit instruction).
    localparam int unsigned PC_INCREMENT_DEF = 4;

    // Fetch sequencer states.
    //   ST_IDLE : nothing requested, responses ignored
    //   ST_REQ  : request presented to instruction memory
    //   ST_WAIT : request accepted, waiting for the response
    //   ST_HOLD : instruction delivered but decode is stalled
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: issues one instruction fetch at a time, steers the PC register, delivers to decode.
// Latency: request accepted -> response -> InstrValid one cycle after the response edge; PcWe/PcD combinational.
// Backpressure: IReqReady holds the request; Stall parks a delivered instruction in HOLD; Tick=0 freezes all state.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter int unsigned NrOfBits    = NR_OF_BITS_DEF,
    parameter int unsigned PcIncrement = PC_INCREMENT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_tick,
    input  logic [NrOfBits-1:0] i_pc_q,
    output logic [NrOfBits-1:0] o_pc_d,
    output logic                o_pc_we,
    output logic                o_ireq_vld,
    input  logic                i_ireq_rdy,
    output logic [NrOfBits-1:0] o_ireq_addr,
    input  logic                i_iresp_vld,
    input  logic [NrOfBits-1:0] i_iresp_dat,
    output logic                o_instr_vld,
    output logic [NrOfBits-1:0] o_instr_dat,
    output logic [NrOfBits-1:0] o_instr_pc,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [NrOfBits-1:0] i_branch_target
);

    localparam logic [NrOfBits-1:0] PC_STEP = NrOfBits'(PcIncrement);

    // Sequencer state and delivered-instruction registers.
    fetch_state_e        r_state;
    logic                r_squash;
    logic                r_instr_vld;
    logic [NrOfBits-1:0] r_instr_dat;
    logic [NrOfBits-1:0] r_instr_pc;
    logic [NrOfBits-1:0] r_fetch_pc;

    // Next-state values; they equal the current values on non-Tick cycles.
    fetch_state_e        w_state_nxt;
    logic                w_squash_nxt;
    logic                w_instr_vld_nxt;
    logic [NrOfBits-1:0] w_instr_dat_nxt;
    logic [NrOfBits-1:0] w_instr_pc_nxt;
    logic [NrOfBits-1:0] w_fetch_pc_nxt;

    logic                w_accept;
    logic                w_redirect;
    logic                w_resp;
    logic [NrOfBits-1:0] w_pc_inc;

    // Handshake qualifiers: everything only counts on a Tick cycle.
    always_comb begin
        w_accept   = (r_state == ST_REQ) && i_ireq_rdy && i_tick;
        w_redirect = i_branch_taken && i_tick;
        w_resp     = i_iresp_vld && i_tick;
        // Plain N-bit add: the carry out is dropped so the PC wraps.
        w_pc_inc   = i_pc_q + PC_STEP;
    end

    // PC register steering: a redirect beats the sequential increment, and an
    // accept issued under squash must not advance the PC.
    always_comb begin
        o_pc_we = 1'b0;
        o_pc_d  = '0;
        if (i_rst_n) begin
            o_pc_we = w_redirect || (w_accept && !r_squash);
            o_pc_d  = i_branch_taken ? i_branch_target : w_pc_inc;
        end
    end

    // Request side: the address is the live PC, which cannot move between
    // issue and accept unless a redirect squashes this fetch anyway.
    always_comb begin
        o_ireq_vld  = (r_state == ST_REQ);
        o_ireq_addr = i_pc_q;
    end

    // Next-state logic for the fetch FSM, squash flag and delivery registers.
    always_comb begin
        w_state_nxt     = r_state;
        w_squash_nxt    = r_squash;
        w_instr_vld_nxt = r_instr_vld;
        w_instr_dat_nxt = r_instr_dat;
        w_instr_pc_nxt  = r_instr_pc;
        w_fetch_pc_nxt  = r_fetch_pc;
        if (i_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    // Stray responses here belong to an abandoned fetch.
                    w_instr_vld_nxt = 1'b0;
                    w_state_nxt     = ST_REQ;
                end
                ST_REQ: begin
                    w_instr_vld_nxt = 1'b0;
                    if (w_redirect) begin
                        w_squash_nxt = 1'b1;
                    end
                    if (w_accept) begin
                        w_fetch_pc_nxt = i_pc_q;
                        w_state_nxt    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    w_instr_vld_nxt = 1'b0;
                    if (w_resp) begin
                        // A response for a stale fetch is dropped and the
                        // squash is spent; a fresh one goes to decode.
                        w_squash_nxt = 1'b0;
                        w_state_nxt  = ST_REQ;
                        if (!w_redirect && !r_squash) begin
                            w_instr_vld_nxt = 1'b1;
                            w_instr_dat_nxt = i_iresp_dat;
                            w_instr_pc_nxt  = r_fetch_pc;
                            if (i_stall) begin
                                w_state_nxt = ST_HOLD;
                            end
                        end
                    end else if (w_redirect) begin
                        w_squash_nxt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Leave when decode takes it, or drop it on a redirect.
                    if (w_redirect || !i_stall) begin
                        w_instr_vld_nxt = 1'b0;
                        w_state_nxt     = ST_REQ;
                    end
                end
                default: begin
                    w_instr_vld_nxt = 1'b0;
                    w_squash_nxt    = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset abandons any outstanding fetch immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_squash    <= 1'b0;
            r_instr_vld <= 1'b0;
            r_instr_dat <= '0;
            r_instr_pc  <= '0;
            r_fetch_pc  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_squash    <= w_squash_nxt;
            r_instr_vld <= w_instr_vld_nxt;
            r_instr_dat <= w_instr_dat_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
        end
    end

    // Decode-facing outputs come straight from the delivery registers.
    always_comb begin
        o_instr_vld = r_instr_vld;
        o_instr_dat = r_instr_dat;
        o_instr_pc  = r_instr_pc;
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Testbench for fetch_pc_sequencer: directed scenarios followed by randomized traffic.
// Latency: reference model advances once per clock, outputs compared after each falling edge.
// Backpressure: random IReqReady, Stall, Tick and redirects; memory returns in 0..2 cycles.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_we;
    logic        ireq_vld;
    logic        ireq_rdy;
    logic [31:0] ireq_addr;
    logic        iresp_vld;
    logic [31:0] iresp_dat;
    logic        instr_vld;
    logic [31:0] instr_dat;
    logic [31:0] instr_pc;
    logic        stall;
    logic        br;
    logic [31:0] tgt;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    fetch_pc_sequencer #(
        .NrOfBits    (32),
        .PcIncrement (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_tick          (tick),
        .i_pc_q          (pc_q),
        .o_pc_d          (pc_d),
        .o_pc_we         (pc_we),
        .o_ireq_vld      (ireq_vld),
        .i_ireq_rdy      (ireq_rdy),
        .o_ireq_addr     (ireq_addr),
        .i_iresp_vld     (iresp_vld),
        .i_iresp_dat     (iresp_dat),
        .o_instr_vld     (instr_vld),
        .o_instr_dat     (instr_dat),
        .o_instr_pc      (instr_pc),
        .i_stall         (stall),
        .i_branch_taken  (br),
        .i_branch_target (tgt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    endtask

    // Reference model: what the fetch unit is doing, in transaction terms.
    localparam int PH_IDLE = 0;   // not fetching
    localparam int PH_ASK  = 1;   // asking memory for the instruction at the PC
    localparam int PH_OUT  = 2;   // a fetch is out in memory
    localparam int PH_PARK = 3;   // an instruction is parked for a stalled decode

    int          m_ph     = PH_IDLE;
    bit          m_stale  = 1'b0;    // the fetch in flight has been overtaken by a redirect
    bit          m_vld    = 1'b0;
    logic [31:0] m_dat    = '0;
    logic [31:0] m_ipc    = '0;
    logic [31:0] m_fpc    = '0;
    logic [31:0] m_pc     = '0;      // the downstream PC register

    // Instruction memory model: one pending reply, content derived from address.
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_dat  = '0;
    int          mem_lat  = 0;       // negative selects a random latency

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic step(input bit r, input bit t, input bit rd, input bit s,
                        input bit b, input logic [31:0] g);
        bit          acc;
        bit          we;
        bit          resp;
        bit          fresh;
        logic [31:0] pcd;
        @(negedge clk);
        cyc++;
        if (!r) begin
            m_ph = PH_IDLE; m_stale = 1'b0; m_vld = 1'b0;
            m_dat = '0; m_ipc = '0; m_fpc = '0;
            mem_cnt = 0;   // an abandoned fetch replies late, right after release
        end
        resp      = mem_pend && (mem_cnt == 0);
        rst_n     = r;
        tick      = t;
        ireq_rdy  = rd;
        stall     = s;
        br        = b;
        tgt       = g;
        pc_q      = m_pc;
        iresp_vld = resp;
        iresp_dat = resp ? mem_dat : 32'hDEAD_BEEF;
        #1;
        acc = r && t && rd && (m_ph == PH_ASK);
        we  = r && t && (b || (acc && !m_stale));
        pcd = !r ? 32'h0 : (b ? g : m_pc + 32'd4);
        chk("pc_we", pc_we, we);
        chk("pc_d", pc_d, pcd);
        chk("ireq_vld", ireq_vld, r && (m_ph == PH_ASK));
        if (r && (m_ph == PH_ASK)) chk("ireq_addr", ireq_addr, m_pc);
        chk("instr_vld", instr_vld, m_vld);
        chk("instr_dat", instr_dat, m_dat);
        chk("instr_pc", instr_pc, m_ipc);
        if (r) begin
            if (t) begin
                case (m_ph)
                    PH_IDLE: m_ph = PH_ASK;
                    PH_ASK: begin
                        m_vld = 1'b0;
                        if (b) m_stale = 1'b1;
                        if (acc) begin m_fpc = m_pc; m_ph = PH_OUT; end
                    end
                    PH_OUT: begin
                        m_vld = 1'b0;
                        if (resp) begin
                            fresh = !b && !m_stale;
                            if (fresh) begin m_vld = 1'b1; m_dat = mem_dat; m_ipc = m_fpc; end
                            m_ph    = (fresh && s) ? PH_PARK : PH_ASK;
                            m_stale = 1'b0;
                        end else if (b) m_stale = 1'b1;
                    end
                    default: if (b || !s) begin m_vld = 1'b0; m_ph = PH_ASK; end
                endcase
                if (resp) mem_pend = 1'b0;
            end
            if (mem_pend && mem_cnt > 0) mem_cnt--;
            if (acc) begin
                mem_pend = 1'b1;
                mem_dat  = mem_word(m_pc);
                mem_cnt  = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 2));
            end
            if (we) m_pc = pcd;
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; ireq_rdy = 1'b0; stall = 1'b0; br = 1'b0;
        tgt = '0; pc_q = '0; iresp_vld = 1'b0; iresp_dat = '0;

        // Basic fetch from PC 0 with a one-cycle memory.
        mem_lat = 0;
        step(0, 1, 1, 0, 0, 0);
        chk("rst_instr_vld", instr_vld, 0);
        chk("rst_ireq_vld", ireq_vld, 0);
        chk("rst_pc_d", pc_d, 0);
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);                    // idle
        chk("t1_idle_ireq", ireq_vld, 0);
        step(1, 1, 1, 0, 0, 0);                    // request accepted
        chk("t1_we", pc_we, 1);
        chk("t1_pcd", pc_d, 32'h4);
        chk("t1_addr", ireq_addr, 32'h0);
        step(1, 1, 1, 0, 0, 0);                    // response arrives
        step(1, 1, 1, 0, 0, 0);                    // delivered
        chk("t1_vld", instr_vld, 1);
        chk("t1_dat", instr_dat, 32'h1234_5678);
        chk("t1_ipc", instr_pc, 32'h0);

        // Delivery under a three-cycle stall.
        step(1, 1, 1, 1, 0, 0);                    // response for PC 4, decode stalled
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, (i < 2), 0, 0);
            chk("t2_vld", instr_vld, 1);
            chk("t2_dat", instr_dat, 32'h1234_567C);
            chk("t2_ipc", instr_pc, 32'h4);
            chk("t2_noreq", ireq_vld, 0);
        end
        mem_lat = 2;
        step(1, 1, 1, 0, 0, 0);                    // released; fetch PC 8
        chk("t2_vld_drop", instr_vld, 0);

        // Redirect while the fetch is out in memory.
        step(1, 1, 1, 0, 1, 32'h100);
        chk("t3_we", pc_we, 1);
        chk("t3_pcd", pc_d, 32'h100);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);                    // stale response dropped
        step(1, 1, 1, 0, 0, 0);
        chk("t3_req", ireq_vld, 1);
        chk("t3_addr", ireq_addr, 32'h100);
        chk("t3_novld", instr_vld, 0);

        // PC wrap at the top of the address space.
        mem_lat = 0;
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'hFFFF_FFFC);        // redirect from idle
        chk("t4_idle_we", pc_we, 1);
        step(1, 1, 1, 0, 0, 0);
        chk("t4_addr", ireq_addr, 32'hFFFF_FFFC);
        chk("t4_we", pc_we, 1);
        chk("t4_wrap", pc_d, 32'h0);

        // Tick low freezes everything.
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 0, 0);
            chk("t5_we", pc_we, 0);
            chk("t5_req", ireq_vld, 1);
        end
        mem_lat = 2;
        step(1, 1, 1, 0, 0, 0);                    // accepted once Tick returns
        chk("t5_accept_we", pc_we, 1);

        // Reset while waiting; the late response must be ignored.
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("t6_resp_late", iresp_vld, 1);
        chk("t6_idle_vld", instr_vld, 0);
        chk("t6_idle_req", ireq_vld, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("t6_vld", instr_vld, 0);
        chk("t6_req", ireq_vld, 1);
        chk("t6_addr", ireq_addr, pc_q);

        // Randomized traffic.
        mem_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            bit          r_v;
            logic [31:0] g_v;
            r_v = ($urandom_range(0, 199) != 0);
            g_v = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(r_v, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 10), g_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
